mul_sched: RTL and testbench
============================

Name: mul_sched

Overview:
- Scheduler that shares one 32x32 signed multiply resource between two requesters (e.g. two issue ports).
- Arbitrates round-robin, latches the winner's operands and holds them stable for a programmable number of cycles.
- Delivers a registered 32-bit result with N/Z/C/V flags over a valid/ready response channel.
- One operation in flight at a time.

Parameters:
- LATENCY, 2: cycles from request handshake to rsp_valid; legal range 1..15.
- TAG_W, 4: width of the requester-supplied tag echoed with the response.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of the operation in flight
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 handshake accepted this cycle
- req0_a  in  32  requester 0 multiplicand, two's complement
- req0_b  in  32  requester 0 multiplier, two's complement
- req0_tag  in  TAG_W  requester 0 tag
- req1_valid, req1_ready, req1_a, req1_b, req1_tag: same as requester 0, for requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester index of the response
- rsp_tag  out  TAG_W  echoed tag
- rsp_result  out  32  low 32 bits of the signed product
- n  out  1  negative flag
- z  out  1  zero flag
- c  out  1  carry flag
- v  out  1  overflow flag
- busy  out  1  state is not IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE, rr_ptr=0, cnt=0. All outputs are 0: rsp_valid, rsp_id, rsp_tag, rsp_result, n, z, c, v, busy, req*_ready.
- States: IDLE, BUSY, DONE.
- IDLE:
  - req*_ready is combinational and goes to the arbitration winner only.
  - Winner is the requester with valid=1. If both are valid, winner is the requester selected by rr_ptr.
  - On handshake: latch a, b, tag and id; rr_ptr <= ~id; cnt <= LATENCY; go to BUSY.
  - With no valid request, stay in IDLE.
- BUSY:
  - Every req*_ready=0.
  - cnt decrements each cycle.
  - When cnt==1, register the product and flags into the rsp_* outputs and go to DONE.
  - Result: rsp_valid rises exactly LATENCY cycles after the handshake edge.
- DONE:
  - rsp_valid=1 and all response fields are held stable while rsp_ready=0.
  - On rsp_ready=1, go to IDLE and drop rsp_valid at that edge.
  - No new grant is made in the DONE cycle. Minimum spacing between handshakes is LATENCY+2 cycles.
- Arithmetic:
  - P = signed(a) * signed(b), 64-bit.
  - rsp_result = P[31:0].
  - n = P[31].
  - z = (P[31:0]==0).
  - c = 0 always.
  - v = 1 when P[63:32] is not the sign extension of P[31], i.e. the signed result does not fit in 32 bits.
- flush=1:
  - In BUSY or DONE: next state IDLE, rsp_valid<=0, result dropped, rr_ptr unchanged from its value at grant.
  - In IDLE: no grant is made that cycle (req*_ready forced 0).
- Simultaneous events:
  - flush has priority over a cnt==1 transition and over rsp_ready.
  - rst_n has priority over everything.
- Reset mid-operation: the operation is lost, no response is produced, and rr_ptr returns to 0.
- Response flag registers are updated only on entry to DONE; reset is the only other event that changes them.
- busy = (state != IDLE).

Decomposition:
- Shared package mul_pkg holds:
  - state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - MUL_W=32
  - flag-bit index constants N/Z/C/V
  - LATENCY range check constant
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: valid[1:0], ptr, enable.
  - Outputs: one-hot grant[1:0] and the granted index.
  - Pointer update stays in mul_sched.
- The signed multiply and flag generation are inline in mul_sched.

Test Plan:
- Basic multiply (LATENCY=2):
  - Stimulus: req0 with a=3, b=4, tag=5; rsp_ready=1.
  - Required: rsp_valid 2 cycles after the handshake, rsp_result=0x0000000C, id=0, tag=5, nzcv=0000, busy drops the cycle after the response.
- Negative product:
  - Stimulus: req1 with a=0xFFFFFFFE (-2), b=3.
  - Required: rsp_result=0xFFFFFFFA, n=1, z=0, v=0, id=1.
- Overflow:
  - Stimulus: a=0x00010000, b=0x00010000.
  - Required: rsp_result=0, z=1, v=1, n=0, c=0.
  - Stimulus: a=0x7FFFFFFF, b=2.
  - Required: result=0xFFFFFFFE, n=1, v=1.
- Contention:
  - Stimulus: req0 and req1 held valid for 4 operations after reset.
  - Required: grants alternate 0,1,0,1; tags echo correctly; no handshake while busy.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles in DONE, then 1.
  - Required: all rsp_* fields are stable for those 5 cycles and both req*_ready stay 0; IDLE and a new grant follow one cycle later.
- Abort and reset:
  - Stimulus: flush in the first BUSY cycle.
  - Required: no rsp_valid and IDLE next cycle.
  - Stimulus: rst_n=0 asynchronously during BUSY.
  - Required: all outputs 0 immediately; a both-valid request after reset is granted to requester 0.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the two-requester multiply scheduler: state
// encoding, datapath width, flag bit positions and latency limits.
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int MUL_W = 32;

    // Bit positions of the packed {n, z, c, v} flag register.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;
    localparam int CNT_W   = 4;

    function automatic bit lat_legal(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone valid requester always wins, a tie
// is broken by ptr_i. The pointer itself is owned by the caller.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    input  logic       enable_i,
    output logic [1:0] grant_o,
    output logic       idx_o
);

    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            if (valid_i == 2'b11) begin
                grant_o = ptr_i ? 2'b10 : 2'b01;
            end else begin
                grant_o = valid_i;
            end
        end
    end

    assign idx_o = grant_o[1];

endmodule

// File: rtl/mul_sched.sv
// Shares one 32x32 signed multiplier between two requesters; one operation
// in flight, result and NZCV flags returned over a valid/ready channel.
module mul_sched
    import mul_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_result,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v,
    output logic             busy
);

    // Handshakes: a request transfers on the edge where its valid and ready
    // are both high; ready is only ever raised in IDLE for the arbitration
    // winner. A response transfers when rsp_valid and rsp_ready are both high.
    localparam logic [CNT_W-1:0] LAT_LOAD =
        lat_legal(LATENCY) ? CNT_W'(LATENCY) : CNT_W'(LAT_MAX);

    state_e             state_q, state_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MUL_W-1:0]   a_q, b_q;
    logic [TAG_W-1:0]   op_tag_q;
    logic               op_id_q;
    logic               rsp_id_q;
    logic [TAG_W-1:0]   rsp_tag_q;
    logic [MUL_W-1:0]   rsp_result_q;
    logic [3:0]         flags_q;

    logic [1:0]         grant;
    logic               gnt_idx;
    logic               load_op;
    logic               load_rsp;
    logic [2*MUL_W-1:0] prod;
    logic [3:0]         flags_d;

    rr_arb2 u_arb (
        .valid_i  ({req1_valid, req0_valid}),
        .ptr_i    (rr_ptr_q),
        .enable_i ((state_q == ST_IDLE) && !flush),
        .grant_o  (grant),
        .idx_o    (gnt_idx)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        load_op  = 1'b0;
        load_rsp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    load_op  = 1'b1;
                    rr_ptr_d = ~gnt_idx;
                    cnt_d    = LAT_LOAD;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    cnt_d    = '0;
                    load_rsp = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (flush || rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Overflow: the upper half must be a pure sign extension of bit 31.
    assign prod = $signed(a_q) * $signed(b_q);

    always_comb begin
        flags_d         = 4'b0000;
        flags_d[FLAG_N] = prod[MUL_W-1];
        flags_d[FLAG_Z] = (prod[MUL_W-1:0] == '0);
        flags_d[FLAG_C] = 1'b0;
        flags_d[FLAG_V] = (prod[2*MUL_W-1:MUL_W] != {MUL_W{prod[MUL_W-1]}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            op_tag_q     <= '0;
            op_id_q      <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_result_q <= '0;
            flags_q      <= 4'b0000;
        end else begin
            if (load_op) begin
                a_q      <= gnt_idx ? req1_a : req0_a;
                b_q      <= gnt_idx ? req1_b : req0_b;
                op_tag_q <= gnt_idx ? req1_tag : req0_tag;
                op_id_q  <= gnt_idx;
            end
            if (load_rsp) begin
                rsp_id_q     <= op_id_q;
                rsp_tag_q    <= op_tag_q;
                rsp_result_q <= prod[MUL_W-1:0];
                flags_q      <= flags_d;
            end
        end
    end

    assign rsp_valid  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_id     = rsp_id_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_result = rsp_result_q;
    assign n          = flags_q[FLAG_N];
    assign z          = flags_q[FLAG_Z];
    assign c          = flags_q[FLAG_C];
    assign v          = flags_q[FLAG_V];

endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched: arithmetic and flags, round-robin contention,
// response backpressure, flush and asynchronous reset mid-operation.
module tb_mul_sched;

    localparam int LAT = 2;
    localparam int TW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          req0_valid, req0_ready;
    logic [31:0]   req0_a, req0_b;
    logic [TW-1:0] req0_tag;
    logic          req1_valid, req1_ready;
    logic [31:0]   req1_a, req1_b;
    logic [TW-1:0] req1_tag;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [TW-1:0] rsp_tag;
    logic [31:0]   rsp_result;
    logic          n, z, c, v, busy;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    mul_sched #(.LATENCY(LAT), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_tag   (req1_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_tag    (rsp_tag),
        .rsp_result (rsp_result),
        .n          (n),
        .z          (z),
        .c          (c),
        .v          (v),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {rsp_valid, rsp_id, rsp_tag, rsp_result, n, z, c, v, busy,
                    req0_ready, req1_ready}, 64'd0);
    endtask

    // Issue one operation from requester r into an idle scheduler and
    // check the response timing and contents.
    task automatic do_op(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tg, input logic [31:0] er,
                         input logic [3:0] enzcv, input string nm);
        if (r == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_tag = tg;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_tag = tg;
        end
        #1;
        check({nm, "_ready"}, {req1_ready, req0_ready}, (r == 0) ? 2'b01 : 2'b10);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check({nm, "_busy"}, {busy, rsp_valid}, 2'b10);
        for (int k = 1; k < LAT; k++) begin
            tick();
            check({nm, "_early"}, rsp_valid, 1'b0);
        end
        tick();
        check({nm, "_valid"}, rsp_valid, 1'b1);
        check({nm, "_result"}, rsp_result, er);
        check({nm, "_id_tag"}, {rsp_id, rsp_tag}, {r[0], tg});
        check({nm, "_nzcv"}, {n, z, c, v}, enzcv);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({nm, "_idle"}, {busy, rsp_valid}, 2'b00);
    endtask

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_tag = '0;
        #2;
        check_all_zero("reset_outputs");
        #10;
        rst_n = 1'b1;
        tick();

        do_op(0, 32'd3, 32'd4, 4'd5, 32'h0000000C, 4'b0000, "basic");
        do_op(1, 32'hFFFFFFFE, 32'd3, 4'd6, 32'hFFFFFFFA, 4'b1000, "neg");
        do_op(0, 32'h00010000, 32'h00010000, 4'd1, 32'h00000000, 4'b0101, "ovf_zero");
        do_op(1, 32'h7FFFFFFF, 32'd2, 4'd2, 32'hFFFFFFFE, 4'b1001, "ovf_pos");
        do_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd15, 32'h00000001, 4'b0000, "negneg");

        // Contention: both requesters held valid from a fresh reset.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd6; req0_tag = 4'd1;
        req1_valid = 1'b1; req1_a = 32'hFFFFFFF9; req1_b = 32'd8; req1_tag = 4'd2;
        rsp_ready = 1'b1;
        #1;
        begin
            int g = 0;
            int rc = 0;
            logic [36:0] e;
            for (int cyc = 0; cyc < 60 && rc < 4; cyc++) begin
                if (busy) check("cont_ready_busy", {req1_ready, req0_ready}, 2'b00);
                if (req0_ready || req1_ready) begin
                    check("cont_grant", {req1_ready, req0_ready}, (g % 2) ? 2'b10 : 2'b01);
                    if (g % 2) exp_q.push_back({1'b1, 4'd2, 32'hFFFFFFC8});
                    else       exp_q.push_back({1'b0, 4'd1, 32'h0000001E});
                    g++;
                end
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("cont_spurious_rsp", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("cont_rsp", {rsp_id, rsp_tag, rsp_result}, e);
                    end
                    rc++;
                    if (rc == 4) begin
                        req0_valid = 1'b0;
                        req1_valid = 1'b0;
                    end
                end
                tick();
            end
            check("cont_rsp_count", rc, 4);
            check("cont_grant_count", g, 4);
            check("cont_queue_empty", exp_q.size(), 0);
        end
        rsp_ready = 1'b0;
        check("cont_idle", busy, 1'b0);

        // Backpressure: hold the response for 5 cycles with req1 waiting.
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_tag = 4'd3;
        #1;
        check("bp_ready", {req1_ready, req0_ready}, 2'b01);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd5; req1_tag = 4'd7;
        for (int k = 0; k < LAT; k++) tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {rsp_valid, rsp_id, rsp_tag, rsp_result, n, z, c, v},
                  {1'b1, 1'b0, 4'd3, 32'h00000051, 4'b0000});
            check("bp_no_grant", {req1_ready, req0_ready}, 2'b00);
            if (i == 4) rsp_ready = 1'b1;
            tick();
        end
        rsp_ready = 1'b0;
        check("bp_release", {busy, rsp_valid}, 2'b00);
        check("bp_new_grant", {req1_ready, req0_ready}, 2'b10);
        tick();
        req1_valid = 1'b0;
        check("flush_busy", busy, 1'b1);

        // Flush in the first BUSY cycle of that new operation.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_idle", {busy, rsp_valid}, 2'b00);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("flush_no_rsp", rsp_valid, 1'b0);
        end

        // Flush in IDLE blocks the grant.
        req0_valid = 1'b1;
        flush = 1'b1;
        #1;
        check("flush_idle_ready", {req1_ready, req0_ready}, 2'b00);
        tick();
        check("flush_idle_stay", busy, 1'b0);
        flush = 1'b0;
        req0_valid = 1'b0;

        // Asynchronous reset while busy; req0 grant had moved the pointer to 1.
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd3; req0_tag = 4'd9;
        tick();
        req0_valid = 1'b0;
        check("rst_op_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_async_outputs");
        #2;
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd4; req0_b = 32'd4; req0_tag = 4'd10;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_tag = 4'd11;
        #1;
        check("rst_rr_winner", {req1_ready, req0_ready}, 2'b01);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            tick();
            check("rst_no_old_rsp", rsp_valid, 1'b0);
        end
        tick();
        check("rst_new_rsp", {rsp_valid, rsp_id, rsp_tag, rsp_result},
              {1'b1, 1'b0, 4'd10, 32'h00000010});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rst_final_idle", {busy, rsp_valid}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
